bin_img_stream_gen: RTL and testbench
=====================================

# bin_img_stream_gen

Parametrised, synthesizable binary-image stream source that drives the `per_img_vsync` / `per_img_href` / `per_img_bit` interface consumed by `CCL` and other binary-image stages.
- Frame size and blanking are parameters.
- Supports single-shot and continuous frame runs.
- Pixels come from one of four sources: an external 1-bit frame memory, checkerboard, LFSR noise, or a border box.
- Used on-chip as a built-in self-test source and in benches in place of file-driven stimulus.

## Interface
- `IMG_W`, 10, pixels per row (≥1)
- `IMG_H`, 10, rows per frame (≥1)
- `V_PRE`, 5, cycles with vsync=1 and href=0 before row 0 (≥1)
- `H_BLANK`, 10, href=0 cycles between consecutive rows (≥1)
- `F_GAP`, 10, vsync=0 cycles after a frame before the next frame or idle (≥1)
- `CELL_LOG2`, 1, log2 of checkerboard cell size
- `LFSR_SEED`, 16'hACE1, LFSR reset value (must be non-zero)
- `ADDR_W`, $clog2(IMG_W*IMG_H), memory address width
- `clk`  in  1  system clock; all logic on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a run; sampled only in IDLE
- `continuous`  in  1  when 1 at the end of F_GAP, start another frame
- `mode`  in  2  pixel source: 0 = memory, 1 = checkerboard, 2 = LFSR, 3 = border box
- `busy`  out  1  high from the first cycle after start is accepted until return to IDLE
- `frame_done`  out  1  one-cycle pulse, coincident with vsync falling
- `mem_rd`  out  1  memory read strobe
- `mem_addr`  out  ADDR_W  pixel address, y*IMG_W+x
- `mem_data`  in  1  read data; valid exactly 1 cycle after mem_rd
- `per_img_vsync`  out  1  frame valid
- `per_img_href`  out  1  pixel valid
- `per_img_bit`  out  1  pixel value

## Operation
- **Reset:** all outputs 0, state IDLE, x = y = 0, blank counter 0, LFSR = LFSR_SEED. Reset is asynchronous and takes effect at any point, including mid-frame; no frame_done is emitted on reset.
- **FSM states:** IDLE → VPRE → LINE → (HBLK → LINE)… → GAP → VPRE or IDLE.
- **IDLE:** `start`=1 moves to VPRE and latches `mode` into `mode_q`. `mode_q` is also relatched at every VPRE entry; mode changes mid-frame take effect on the next frame. `start` is ignored outside IDLE.
- **VPRE:** vsync=1, href=0 for V_PRE cycles, then LINE with x=0.
- **LINE:** href=1 for IMG_W cycles; x increments each cycle.
  - After x=IMG_W-1: if y<IMG_H-1, go to HBLK and increment y.
  - After the last row, go to GAP.
- **HBLK:** vsync=1, href=0 for H_BLANK cycles. There is no HBLK after the last row.
- **GAP:** vsync=0, href=0, `frame_done`=1 in its first cycle.
  - Lasts F_GAP cycles.
  - At exit, sampled `continuous`=1 → VPRE with y=0; otherwise IDLE and busy falls.
- **Pixel sources (`mode_q`):**
  - **0, memory:** `mem_rd`=1 and `mem_addr`=y*IMG_W+x are issued one cycle ahead of each href cycle; `per_img_bit` is registered from `mem_data`. `mem_rd` is 0 at all other times, and addr holds its last value.
  - **1, checkerboard:** bit = (x>>CELL_LOG2) ^ (y>>CELL_LOG2), bit 0.
  - **2, LFSR:** 16-bit Fibonacci LFSR, taps 16,14,13,11.
    - bit = lfsr[0]; shifts once per href cycle.
    - Continues across frames and is reseeded only by reset.
  - **3, border box:** bit = 1 when x==0, x==IMG_W-1, y==0 or y==IMG_H-1, else 0.
- `per_img_bit` is forced to 0 whenever href=0.
- **Widths:**
  - x: $clog2(IMG_W+1) bits.
  - y: $clog2(IMG_H+1) bits.
  - Blank counter: wide enough for max(V_PRE, H_BLANK, F_GAP).
  - Address arithmetic is done at ADDR_W bits with no wrap inside a frame.

## Timing
- `start` sampled high at edge k: busy=1 and vsync=1 from edge k+1.
- The first href=1 follows at edge k+1+V_PRE.
- All data outputs are registered and the three stream signals change on the same edge, so there is no skew between vsync, href and bit.
- vsync-high length per frame = V_PRE + IMG_W*IMG_H + (IMG_H-1)*H_BLANK cycles.
- The vsync fall and `frame_done` occur on the edge after the last pixel, together with href fall.
- Frame period in continuous mode = vsync-high length + F_GAP.
- Memory mode: `mem_rd`/`mem_addr` lead the matching href pixel by exactly 1 cycle; the pixel-to-address latency is fixed regardless of blanking.
- `start` and `continuous` both high at GAP exit: continue; `start` has no extra effect.

## Test plan
- **Default params, mode 3, single start:**
  - vsync=1 for 5 cycles before the first href.
  - 10 rows of 10 href cycles with 10-cycle gaps between them.
  - Row 0 = all 1s; rows 1–8 = 1,0×8,1; row 9 = all 1s.
  - vsync-high length 195 cycles; exactly one `frame_done`; busy returns to 0 after 10 GAP cycles.
- **Mode 0 with a memory model holding a known 100-bit pattern:**
  - `mem_addr` sequence is 0..99.
  - Each `per_img_bit` equals mem[addr] of the previous cycle's `mem_rd`.
  - `mem_rd` count is 100.
- **Mode 1, CELL_LOG2=1:** row 0 = 0,0,1,1,0,0,1,1,0,0; row 2 = 1,1,0,0,1,1,0,0,1,1.
- **continuous=1, 4 frames:**
  - vsync fall-to-rise spacing is exactly 10 cycles.
  - Clear `continuous` during frame 4: the run stops after frame 4.
  - A `start` pulse mid-frame is ignored.
  - A mode change 2→3 mid-frame applies from the next frame only.
- **Mode 2:** the first 16 href bits match the software LFSR from seed 16'hACE1, and the second frame continues the same sequence without a reseed.
- **Reset asserted mid-row (row 4, x=5):**
  - All outputs are 0 immediately, with no `frame_done`.
  - After release, `start` yields a fresh frame beginning at row 0, and the LFSR is back at the seed.

Source files
------------

// File: rtl/bin_img_stream_gen_if.sv
// Control, pixel-memory and binary-image stream signals of bin_img_stream_gen.
interface bin_img_stream_gen_if #(
    parameter int ADDR_W = 7
);
    logic              start;
    logic              continuous;
    logic [1:0]        mode;
    logic              busy;
    logic              frame_done;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data;
    logic              per_img_vsync;
    logic              per_img_href;
    logic              per_img_bit;

    modport master (
        input  start, continuous, mode, mem_data,
        output busy, frame_done, mem_rd, mem_addr,
        output per_img_vsync, per_img_href, per_img_bit
    );

    modport slave (
        output start, continuous, mode, mem_data,
        input  busy, frame_done, mem_rd, mem_addr,
        input  per_img_vsync, per_img_href, per_img_bit
    );
endinterface

// File: rtl/bin_img_stream_gen.sv
// Binary-image stream source (vsync/href/bit) with memory, checkerboard, LFSR and
// border-box pixel sources; single-shot or continuous frame runs.
module bin_img_stream_gen #(
    parameter int          IMG_W     = 10,
    parameter int          IMG_H     = 10,
    parameter int          V_PRE     = 5,
    parameter int          H_BLANK   = 10,
    parameter int          F_GAP     = 10,
    parameter int          CELL_LOG2 = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          ADDR_W    = $clog2(IMG_W * IMG_H)
) (
    input  logic                clk,
    input  logic                rst_n,
    bin_img_stream_gen_if.master bus
);
    localparam int XW    = $clog2(IMG_W + 1);
    localparam int YW    = $clog2(IMG_H + 1);
    localparam int BMAX0 = (V_PRE > H_BLANK) ? V_PRE : H_BLANK;
    localparam int BMAX  = (BMAX0 > F_GAP) ? BMAX0 : F_GAP;
    localparam int CW    = $clog2(BMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VPRE,
        S_LINE,
        S_HBLK,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              lfsr_fb;

    logic              busy_q, done_q, vsync_q, href_q, bit_q, rd_q;
    logic              busy_d, done_d, vsync_d, href_d, bit_d, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    function automatic logic pattern_bit(input logic [1:0]    m,
                                         input logic [XW-1:0] x,
                                         input logic [YW-1:0] y,
                                         input logic          lfsr_bit,
                                         input logic          mem_bit);
        logic [XW-1:0] xc;
        logic [YW-1:0] yc;
        xc = x >> CELL_LOG2;
        yc = y >> CELL_LOG2;
        case (m)
            2'd0:    pattern_bit = mem_bit;
            2'd1:    pattern_bit = xc[0] ^ yc[0];
            2'd2:    pattern_bit = lfsr_bit;
            default: pattern_bit = (x == XW'(0)) || (x == XW'(IMG_W - 1)) ||
                                   (y == YW'(0)) || (y == YW'(IMG_H - 1));
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [XW-1:0] x,
                                                   input logic [YW-1:0] y);
        pix_addr = ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
    endfunction

    // Fibonacci taps 16,14,13,11 in right-shift form
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        lfsr_d  = lfsr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_VPRE;
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                    mode_d  = bus.mode;
                end
            end
            S_VPRE: begin
                if (cnt_q == CW'(V_PRE - 1)) begin
                    state_d = S_LINE;
                    cnt_d   = '0;
                    x_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LINE: begin
                if (mode_q == 2'd2) lfsr_d = {lfsr_fb, lfsr_q[15:1]};
                if (x_q == XW'(IMG_W - 1)) begin
                    x_d   = '0;
                    cnt_d = '0;
                    if (y_q == YW'(IMG_H - 1)) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_HBLK;
                        y_d     = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            S_HBLK: begin
                if (cnt_q == CW'(H_BLANK - 1)) begin
                    state_d = S_LINE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(F_GAP - 1)) begin
                    cnt_d = '0;
                    if (bus.continuous) begin
                        state_d = S_VPRE;
                        x_d     = '0;
                        y_d     = '0;
                        mode_d  = bus.mode;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The FSM runs one cycle ahead of the registered stream outputs; the memory
        // request is issued from the next state so it leads its pixel by one cycle,
        // and mem_data is captured on the edge that closes the mem_rd cycle.
        busy_d  = (state_q != S_IDLE);
        done_d  = (state_q == S_GAP) && (cnt_q == '0);
        vsync_d = (state_q == S_VPRE) || (state_q == S_LINE) || (state_q == S_HBLK);
        href_d  = (state_q == S_LINE);
        bit_d   = href_d && pattern_bit(mode_q, x_q, y_q, lfsr_q[0], bus.mem_data);
        rd_d    = (state_d == S_LINE) && (mode_q == 2'd0);
        addr_d  = rd_d ? pix_addr(x_d, y_d) : addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            bit_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            lfsr_q  <= lfsr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            bit_q   <= bit_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.frame_done    = done_q;
    assign bus.per_img_vsync = vsync_q;
    assign bus.per_img_href  = href_q;
    assign bus.per_img_bit   = bit_q;
    assign bus.mem_rd        = rd_q;
    assign bus.mem_addr      = addr_q;

endmodule

// File: tb/tb_bin_img_stream_gen.sv
// Directed bench for bin_img_stream_gen at default parameters.
module tb_bin_img_stream_gen;
    localparam int ADDR_W = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin_img_stream_gen_if #(.ADDR_W(ADDR_W)) bus ();

    bin_img_stream_gen #(
        .IMG_W(10), .IMG_H(10), .V_PRE(5), .H_BLANK(10), .F_GAP(10),
        .CELL_LOG2(1), .LFSR_SEED(16'hACE1), .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Asynchronous-read pixel memory
    logic mem [0:127];
    assign bus.mem_data = mem[bus.mem_addr];

    int n_cmp = 0;
    int n_bad = 0;

    int bits[$], rise_t[$], fall_t[$], hr[$], hf[$], bf[$], addrs[$], mexp[$];
    int cyc = 0, done_cnt = 0, done_mis = 0, bad_bit = 0, rd_cnt = 0, lead_err = 0;
    logic pv = 1'b0, ph = 1'b0, pb = 1'b0, prd = 1'b0;
    logic [ADDR_W-1:0] pa = '0;
    int seq [400];

    int SEED_BITS [16] = '{1,0,0,0, 0,1,1,1, 0,0,1,1, 0,1,0,1};
    int CB0 [10]       = '{0,0,1,1,0,0,1,1,0,0};
    int CB2 [10]       = '{1,1,0,0,1,1,0,0,1,1};
    int BOX_MID [10]   = '{1,0,0,0,0,0,0,0,0,1};

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int box_exp(input int idx);
        int r;
        r = idx / 10;
        return (r == 0 || r == 9) ? 1 : BOX_MID[idx % 10];
    endfunction

    task automatic clear();
        bits.delete(); rise_t.delete(); fall_t.delete(); hr.delete(); hf.delete();
        bf.delete(); addrs.delete(); mexp.delete();
        done_cnt = 0; done_mis = 0; bad_bit = 0; rd_cnt = 0; lead_err = 0;
    endtask

    task automatic start_run(input logic [1:0] m);
        @(negedge clk);
        bus.mode  = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", bus.busy, 0);
    endtask

    task automatic chk_outs_zero(input string pfx);
        chk({pfx, "_vsync"}, bus.per_img_vsync, 0);
        chk({pfx, "_href"},  bus.per_img_href, 0);
        chk({pfx, "_bit"},   bus.per_img_bit, 0);
        chk({pfx, "_busy"},  bus.busy, 0);
        chk({pfx, "_done"},  bus.frame_done, 0);
        chk({pfx, "_memrd"}, bus.mem_rd, 0);
    endtask

    // Stream monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.per_img_href) bits.push_back(int'(bus.per_img_bit));
            if (bus.per_img_bit && !bus.per_img_href) bad_bit++;
            if (bus.frame_done) begin
                done_cnt++;
                if (!(pv && !bus.per_img_vsync)) done_mis++;
            end
            if (bus.per_img_vsync && !pv) rise_t.push_back(cyc);
            if (!bus.per_img_vsync && pv) fall_t.push_back(cyc);
            if (bus.per_img_href && !ph) hr.push_back(cyc);
            if (!bus.per_img_href && ph) hf.push_back(cyc);
            if (!bus.busy && pb) bf.push_back(cyc);
            if (bus.mem_rd) begin
                rd_cnt++;
                addrs.push_back(int'(bus.mem_addr));
            end
            if (bus.per_img_href != prd) lead_err++;
            if (bus.per_img_href && prd) mexp.push_back(int'(mem[pa]));
            pv  = bus.per_img_vsync;
            ph  = bus.per_img_href;
            pb  = bus.busy;
            prd = bus.mem_rd;
            pa  = bus.mem_addr;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [99:0] pat;
        logic [15:0] l;
        logic        fb;
        pat = 100'h5A3C_96E1_0F7B_2D48_C31E_A6D9_B;
        for (int i = 0; i < 128; i++) mem[i] = (i < 100) ? pat[i] : 1'b0;
        l = 16'hACE1;
        for (int i = 0; i < 400; i++) begin
            seq[i] = int'(l[0]);
            fb = l[0] ^ l[2] ^ l[3] ^ l[5];
            l  = {fb, l[15:1]};
        end

        bus.start = 1'b0; bus.continuous = 1'b0; bus.mode = 2'd0;
        repeat (3) @(negedge clk);
        chk_outs_zero("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Border box, single shot
        clear();
        start_run(2'd3);
        chk("k_vsync", bus.per_img_vsync, 0);
        @(negedge clk);
        chk("k1_busy", bus.busy, 1);
        chk("k1_vsync", bus.per_img_vsync, 1);
        wait_idle(1000);
        chk("box_frames", rise_t.size(), 1);
        chk("box_vs_len", qat(fall_t, 0) - qat(rise_t, 0), 195);
        chk("box_pre", qat(hr, 0) - qat(rise_t, 0), 5);
        chk("box_rows", hr.size(), 10);
        for (int r = 0; r < 10; r++) begin
            chk($sformatf("box_rowlen%0d", r), qat(hf, r) - qat(hr, r), 10);
            if (r < 9) chk($sformatf("box_hblk%0d", r), qat(hr, r + 1) - qat(hf, r), 10);
        end
        chk("box_nbits", bits.size(), 100);
        for (int i = 0; i < 100; i++) chk($sformatf("box_px%0d", i), qat(bits, i), box_exp(i));
        chk("box_done_cnt", done_cnt, 1);
        chk("box_done_align", done_mis, 0);
        chk("box_busy_gap", qat(bf, 0) - qat(fall_t, 0), 10);
        chk("box_bit_no_href", bad_bit, 0);

        // Memory source
        clear();
        start_run(2'd0);
        wait_idle(1000);
        chk("mem_rd_cnt", rd_cnt, 100);
        chk("mem_nbits", bits.size(), 100);
        chk("mem_lead", lead_err, 0);
        for (int i = 0; i < 100; i++) begin
            chk($sformatf("mem_addr%0d", i), qat(addrs, i), i);
            chk($sformatf("mem_px%0d", i), qat(bits, i), int'(mem[i]));
            chk($sformatf("mem_prev%0d", i), qat(bits, i), qat(mexp, i));
        end

        // Checkerboard, 2x2 cells
        clear();
        start_run(2'd1);
        wait_idle(1000);
        for (int x = 0; x < 10; x++) begin
            chk($sformatf("cb_r0_x%0d", x), qat(bits, x), CB0[x]);
            chk($sformatf("cb_r2_x%0d", x), qat(bits, 20 + x), CB2[x]);
        end

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // LFSR across two single-shot frames
        clear();
        start_run(2'd2);
        wait_idle(1000);
        start_run(2'd2);
        wait_idle(1000);
        chk("lfsr_nbits", bits.size(), 200);
        for (int i = 0; i < 16; i++) chk($sformatf("lfsr_seed%0d", i), qat(bits, i), SEED_BITS[i]);
        for (int i = 0; i < 200; i++) chk($sformatf("lfsr_px%0d", i), qat(bits, i), seq[i]);

        // Continuous run of four frames
        clear();
        bus.continuous = 1'b1;
        start_run(2'd2);
        repeat (50) @(negedge clk);
        bus.mode = 2'd3;
        repeat (250) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (400) @(negedge clk);
        bus.continuous = 1'b0;
        wait_idle(3000);
        chk("cont_frames", rise_t.size(), 4);
        chk("cont_falls", fall_t.size(), 4);
        chk("cont_done_cnt", done_cnt, 4);
        chk("cont_done_align", done_mis, 0);
        for (int f = 0; f < 4; f++) begin
            chk($sformatf("cont_vs_len%0d", f), qat(fall_t, f) - qat(rise_t, f), 195);
            if (f < 3) chk($sformatf("cont_gap%0d", f), qat(rise_t, f + 1) - qat(fall_t, f), 10);
        end
        chk("cont_busy_gap", qat(bf, 0) - qat(fall_t, 3), 10);
        chk("cont_nbits", bits.size(), 400);
        for (int i = 0; i < 100; i++) chk($sformatf("cont_f1_px%0d", i), qat(bits, i), seq[200 + i]);
        for (int i = 100; i < 400; i++) chk($sformatf("cont_box_px%0d", i), qat(bits, i), box_exp(i % 100));

        // Reset in the middle of row 4
        clear();
        start_run(2'd2);
        repeat (91) @(negedge clk);
        chk("pre_rst_href", bus.per_img_href, 1);
        chk("pre_rst_nbits", bits.size(), 46);
        rst_n = 1'b0;
        #1;
        chk_outs_zero("midrst");
        chk("midrst_done_cnt", done_cnt, 0);
        repeat (3) @(negedge clk);
        chk("midrst_done_hold", done_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        clear();
        start_run(2'd2);
        wait_idle(1000);
        chk("post_frames", rise_t.size(), 1);
        chk("post_pre", qat(hr, 0) - qat(rise_t, 0), 5);
        chk("post_nbits", bits.size(), 100);
        chk("post_done_cnt", done_cnt, 1);
        for (int i = 0; i < 16; i++) chk($sformatf("post_seed%0d", i), qat(bits, i), SEED_BITS[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
